// File: rtl/atm_keypad_frontend.sv
// ATM keypad front end: collects account, PIN, operation, destination and amount
// from a key strobe stream and presents them as one record with a valid/ready handshake.
module atm_keypad_frontend #(
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_in,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        rec_ready,
  output logic        rec_valid,
  output logic [11:0] account_number,
  output logic [11:0] pin,
  output logic [11:0] dst_account,
  output logic [11:0] amount,
  output logic [2:0]  operation,
  output logic [2:0]  prompt,
  output logic        err,
  output logic        cancelled
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, ACCT = 3'd1, PIN = 3'd2, OP = 3'd3, DST = 3'd4, AMT = 3'd5, SEND = 3'd6
  } state_t;

  localparam logic [2:0]  OP_BALANCE  = 3'b010;
  localparam logic [2:0]  OP_TRANSFER = 3'b011;
  localparam logic [2:0]  OP_EXIT     = 3'b100;
  localparam logic [3:0]  K_ENTER     = 4'hA;
  localparam logic [3:0]  K_BACK      = 4'hB;
  localparam logic [3:0]  K_CANCEL    = 4'hC;
  localparam logic [15:0] IDLE_LIMIT  = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [11:0] buf_q, buf_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] idle_q, idle_d;
  logic [11:0] acct_q, acct_d, pin_q, pin_d, dst_q, dst_d, amt_q, amt_d;
  logic [2:0]  op_q, op_d;
  logic        err_q, err_d, canc_q, canc_d;
  logic        in_entry;

  // Handshake: the record is offered while rec_valid is high and is consumed on the
  // first clock edge where rec_valid && rec_ready; fields do not move until then.
  assign rec_valid      = (state_q == SEND);
  assign prompt         = state_q;
  assign account_number = acct_q;
  assign pin            = pin_q;
  assign dst_account    = dst_q;
  assign amount         = amt_q;
  assign operation      = op_q;
  assign err            = err_q;
  assign cancelled      = canc_q;
  assign in_entry       = (state_q != IDLE) && (state_q != SEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      acct_q  <= '0;
      pin_q   <= '0;
      dst_q   <= '0;
      amt_q   <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
      canc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      acct_q  <= acct_d;
      pin_q   <= pin_d;
      dst_q   <= dst_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      err_q   <= err_d;
      canc_q  <= canc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    acct_d  = acct_q;
    pin_d   = pin_q;
    dst_d   = dst_q;
    amt_d   = amt_q;
    op_d    = op_q;
    err_d   = 1'b0;
    canc_d  = 1'b0;

    // Card removal outranks keys, timeout and the handshake.
    if (state_q != IDLE && !card_in) begin
      state_d = IDLE;
      canc_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (card_in) state_d = ACCT;
        SEND: begin
          if (rec_ready) begin
            dst_d = '0;
            amt_d = '0;
            state_d = (op_q == OP_EXIT) ? IDLE : OP;
          end
        end
        default: begin
          if (key_valid) begin
            if (key_code <= 4'd9) begin
              if (cnt_q != 2'd3) begin
                buf_d = {buf_q[7:0], key_code};
                cnt_d = cnt_q + 2'd1;
              end
            end else if (key_code == K_BACK) begin
              if (cnt_q != 2'd0) begin
                buf_d = buf_q >> 4;
                cnt_d = cnt_q - 2'd1;
              end
            end else if (key_code == K_CANCEL) begin
              state_d = IDLE;
              canc_d  = 1'b1;
            end else if (key_code == K_ENTER && cnt_q != 2'd0) begin
              buf_d = '0;
              cnt_d = '0;
              case (state_q)
                ACCT: begin acct_d = buf_q; state_d = PIN; end
                PIN:  begin pin_d  = buf_q; state_d = OP;  end
                DST:  begin dst_d  = buf_q; state_d = AMT; end
                AMT: begin
                  if (buf_q == 12'd0) err_d = 1'b1;
                  else begin amt_d = buf_q; state_d = SEND; end
                end
                default: begin
                  if (cnt_q == 2'd1 && buf_q <= 12'd4) begin
                    op_d = buf_q[2:0];
                    if (buf_q[2:0] == OP_TRANSFER) state_d = DST;
                    else if (buf_q[2:0] == OP_BALANCE || buf_q[2:0] == OP_EXIT) begin
                      dst_d = '0;
                      amt_d = '0;
                      state_d = SEND;
                    end else state_d = AMT;
                  end else err_d = 1'b1;
                end
              endcase
            end
          end else if (idle_q == IDLE_LIMIT) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      endcase
    end

    // Every return to IDLE wipes the session.
    if (state_d == IDLE && state_q != IDLE) begin
      buf_d  = '0;
      cnt_d  = '0;
      acct_d = '0;
      pin_d  = '0;
      dst_d  = '0;
      amt_d  = '0;
      op_d   = '0;
    end

    idle_d = '0;
    if (in_entry && !key_valid && state_d == state_q) idle_d = idle_q + 16'd1;
  end

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Directed bench for atm_keypad_frontend: full sessions, editing keys, rejected
// entries, idle timeout, cancellation, card removal in SEND and async reset.
module tb_atm_keypad_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic        card_in, key_valid, rec_ready;
  logic [3:0]  key_code;
  logic        rec_valid, err, cancelled;
  logic [11:0] account_number, pin, dst_account, amount;
  logic [2:0]  operation, prompt;

  int pass_cnt = 0;
  int total_cnt = 0;

  atm_keypad_frontend #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .key_valid(key_valid), .key_code(key_code),
    .rec_ready(rec_ready), .rec_valid(rec_valid), .account_number(account_number), .pin(pin),
    .dst_account(dst_account), .amount(amount), .operation(operation), .prompt(prompt),
    .err(err), .cancelled(cancelled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present one key for one cycle; returns #1 after the edge that consumed it.
  task automatic key(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; card_in = 1'b0; key_valid = 1'b0; key_code = 4'h0; rec_ready = 1'b0;
    cycle(); cycle();
    chk("rst_prompt", 16'(prompt), 16'd0);
    chk("rst_rec_valid", 16'(rec_valid), 16'd0);
    chk("rst_err_canc", {14'd0, err, cancelled}, 16'd0);
    chk("rst_fields", 16'(account_number | pin | dst_account | amount), 16'd0);
    @(negedge clk); rst = 1'b0;

    // Keys in IDLE are ignored, then card insertion moves to ACCT.
    key(4'h1);
    chk("idle_key_ignored", 16'(prompt), 16'd0);
    @(negedge clk); card_in = 1'b1;
    cycle();
    chk("card_to_acct", 16'(prompt), 16'd1);

    // Withdraw session.
    key(4'h1); key(4'h2); key(4'h3); key(4'hA);
    chk("acct_commit", 16'(account_number), 16'h123);
    chk("to_pin", 16'(prompt), 16'd2);
    key(4'h4); key(4'h5); key(4'h6); key(4'hA);
    chk("pin_commit", 16'(pin), 16'h456);
    chk("to_op", 16'(prompt), 16'd3);
    key(4'h1); key(4'hA);
    chk("op_withdraw", 16'(operation), 16'd1);
    chk("to_amt", 16'(prompt), 16'd5);
    key(4'h0); key(4'h5); key(4'h0); key(4'hA);
    chk("send_valid", 16'(rec_valid), 16'd1);
    chk("amt_commit", 16'(amount), 16'h050);
    @(negedge clk); rec_ready = 1'b1;
    cycle();
    @(negedge clk); rec_ready = 1'b0;
    chk("hs_valid_drop", 16'(rec_valid), 16'd0);
    chk("hs_prompt_op", 16'(prompt), 16'd3);
    chk("hs_keep_acct", 16'(account_number), 16'h123);
    chk("hs_clear_amt", 16'(amount), 16'h000);

    // Transfer with rejected zero amount and back-pressure.
    key(4'h3); key(4'hA);
    chk("to_dst", 16'(prompt), 16'd4);
    key(4'h2); key(4'h0); key(4'h1); key(4'hA);
    chk("dst_commit", 16'(dst_account), 16'h201);
    key(4'h0); key(4'hA);
    chk("amt_zero_err", 16'(err), 16'd1);
    chk("amt_zero_stay", 16'(prompt), 16'd5);
    cycle();
    chk("err_one_cycle", 16'(err), 16'd0);
    key(4'h9); key(4'hA);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 16'(rec_valid), 16'd1);
      chk("hold_dst", 16'(dst_account), 16'h201);
      chk("hold_amt", 16'(amount), 16'h009);
      cycle();
    end
    chk("hold_op", 16'(operation), 16'd3);
    @(negedge clk); rec_ready = 1'b1;
    cycle();
    @(negedge clk); rec_ready = 1'b0;
    chk("xfer_hs_prompt", 16'(prompt), 16'd3);
    chk("xfer_hs_dst_clr", 16'(dst_account), 16'h000);

    // Rejected operation and ignored empty ENTER in OP.
    key(4'h5); key(4'hA);
    chk("op_bad_err", 16'(err), 16'd1);
    chk("op_bad_stay", 16'(prompt), 16'd3);
    chk("op_bad_keep", 16'(operation), 16'd3);
    key(4'hA);
    chk("op_empty_noerr", 16'(err), 16'd0);

    // CANCEL, then digit overflow and backspace editing in ACCT.
    key(4'hC);
    chk("cancel_pulse", 16'(cancelled), 16'd1);
    chk("cancel_prompt", 16'(prompt), 16'd0);
    chk("cancel_clear", 16'(account_number | pin), 16'd0);
    cycle();
    chk("cancel_one_cycle", 16'(cancelled), 16'd0);
    chk("reenter_acct", 16'(prompt), 16'd1);
    key(4'h7); key(4'h8); key(4'h9); key(4'h4); key(4'hB); key(4'hB); key(4'hA);
    chk("edit_acct", 16'(account_number), 16'h007);

    // Timeout in PIN after 8 idle cycles.
    for (int i = 0; i < 7; i++) cycle();
    chk("pre_timeout_prompt", 16'(prompt), 16'd2);
    chk("pre_timeout_err", 16'(err), 16'd0);
    cycle();
    chk("timeout_err", 16'(err), 16'd1);
    chk("timeout_prompt", 16'(prompt), 16'd0);
    chk("timeout_clear", 16'(account_number), 16'h000);
    cycle();
    chk("timeout_reacct", 16'(prompt), 16'd1);

    // A key on the last idle cycle prevents the timeout and restarts the count.
    for (int i = 0; i < 7; i++) cycle();
    key(4'h1);
    chk("key_beats_timeout_err", 16'(err), 16'd0);
    chk("key_beats_timeout_prompt", 16'(prompt), 16'd1);
    for (int i = 0; i < 6; i++) cycle();
    chk("counter_restarted", 16'(prompt), 16'd1);

    // Balance query straight to SEND, keys ignored there, then card removal.
    key(4'hA); key(4'h2); key(4'hA); key(4'h2); key(4'hA);
    chk("bal_send", 16'(prompt), 16'd6);
    chk("bal_fields", {pin, 1'b0, operation}, {12'h002, 4'h2});
    key(4'hC);
    chk("send_key_ignored", {13'd0, prompt}, {13'd0, 3'd6});
    chk("send_no_cancel", 16'(cancelled), 16'd0);
    @(negedge clk); card_in = 1'b0;
    cycle();
    chk("pull_valid", 16'(rec_valid), 16'd0);
    chk("pull_cancel", 16'(cancelled), 16'd1);
    chk("pull_fields", 16'(account_number | pin | dst_account | amount | 12'(operation)), 16'd0);

    // Asynchronous reset mid-session.
    @(negedge clk); card_in = 1'b1;
    cycle();
    key(4'h4);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("async_rst_prompt", 16'(prompt), 16'd0);
    chk("async_rst_pulses", {14'd0, err, cancelled}, 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
